// File: rtl/binary_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// slave = converter side, master = upstream/downstream driver side.
interface binary_to_bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      binary_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  busy;

   modport slave (
      input  in_valid, binary_in, out_ready,
      output in_ready, out_valid, bcd_out, busy
   );

   modport master (
      output in_valid, binary_in, out_ready,
      input  in_ready, out_valid, bcd_out, busy
   );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: one WIDTH-bit word in, DIGITS packed
// BCD digits out, one iteration per clock, valid/ready on both sides.

// Add-3 correction for a single BCD digit (applied before each shift).
module binary_to_bcd_seq_adj3 (
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);
   assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module binary_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   binary_to_bcd_seq_if.slave   bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   function automatic longint unsigned pow10(input int n);
      longint unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam longint unsigned MAX_IN = (64'd1 << WIDTH) - 64'd1;

   // Digit count must cover the full input range, otherwise the top carry is lost.
   generate
      if (WIDTH < 2 || WIDTH > 62) begin : g_bad_width
         $error("binary_to_bcd_seq: WIDTH out of supported range");
      end
      if (!(pow10(DIGITS) > MAX_IN)) begin : g_bad_digits
         $error("binary_to_bcd_seq: 10**DIGITS must exceed 2**WIDTH-1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     out_q, out_d;
   logic              out_valid_q, out_valid_d;

   logic [BW-1:0]     bcd_adj;
   logic [BW-1:0]     bcd_shift;
   logic [WIDTH-1:0]  bin_shift;

   // All digit corrections happen in parallel, one instance per digit.
   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_dig
         binary_to_bcd_seq_adj3 u_adj (
            .dig_i (bcd_q[4*g +: 4]),
            .dig_o (bcd_adj[4*g +: 4])
         );
      end
   endgenerate

   // Shift {corrected bcd, bin} left by one; bin MSB feeds the units digit.
   assign bcd_shift = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
   assign bin_shift = {bin_q[WIDTH-2:0], 1'b0};

   // Next-state and datapath updates for IDLE/SHIFT/DONE.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               bin_d   = bus.binary_in;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bin_d = bin_shift;
            bcd_d = bcd_shift;
            cnt_d = cnt_q + 1'b1;
            // Final iteration publishes the freshly shifted value directly.
            if (cnt_q == LAST) begin
               out_d       = bcd_shift;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q == SHIFT);
   assign bus.out_valid = out_valid_q;
   assign bus.bcd_out   = out_q;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench: accepted words push their decimal expansion into a
// queue; a negedge monitor pops and compares on every output handshake.
module tb_binary_to_bcd_seq;
   logic clk;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   rnd_or = 0;
   bit   ov_prev = 0;

   logic [11:0] exp_q[$];
   int          acc_q[$];
   int          rise_q[$];

   binary_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) bus8 ();
   binary_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus16 ();

   binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: repeated divide-by-ten, one nibble per decimal digit.
   function automatic logic [31:0] ref_bcd(input int unsigned v);
      logic [31:0] r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic bit all_bcd(input logic [11:0] b);
      return (b[3:0] <= 9) && (b[7:4] <= 9) && (b[11:8] <= 9);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: latency on out_valid rise, value on handshake, accept capture.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus8.out_valid && !ov_prev) begin
            rise_q.push_back(cyc);
            if (acc_q.size() == 0) chk("spurious_valid", 1, 0);
            else chk("latency", cyc - acc_q[0], 8);
         end
         if (bus8.out_valid && bus8.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", bus8.bcd_out, 0);
            else begin
               chk("bcd_out", bus8.bcd_out, exp_q[0]);
               chk("digits_valid", all_bcd(bus8.bcd_out), 1);
               void'(exp_q.pop_front());
               void'(acc_q.pop_front());
            end
         end
         if (bus8.in_valid && bus8.in_ready) begin
            exp_q.push_back(ref_bcd(bus8.binary_in)[11:0]);
            acc_q.push_back(cyc + 1);
         end
         ov_prev <= bus8.out_valid;
      end else begin
         ov_prev <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_or) bus8.out_ready = 1'($urandom_range(0, 1));
   endtask

   // Offer a word and hold it until the converter takes it.
   task automatic send(input int v);
      bit got = 0;
      bus8.in_valid  = 1'b1;
      bus8.binary_in = 8'(v);
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bus8.in_ready) got = 1;
         tick();
      end
      if (!got) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic wait_ov(input int bound);
      bit seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (bus8.out_valid) seen = 1;
      end
      if (!seen) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic conv16(input int unsigned v, input logic [19:0] exp);
      int  acc;
      bit  seen = 0;
      @(posedge clk); #1;
      bus16.in_valid  = 1'b1;
      bus16.binary_in = 16'(v);
      @(negedge clk);
      chk("w16_in_ready", bus16.in_ready, 1);
      acc = cyc + 1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus16.out_valid) seen = 1;
      end
      chk("w16_seen", seen, 1);
      chk("w16_latency", cyc - acc, 16);
      chk("w16_bcd_out", bus16.bcd_out, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      bus8.in_valid = 1'b0;   bus8.binary_in = '0;  bus8.out_ready = 1'b1;
      bus16.in_valid = 1'b0;  bus16.binary_in = '0; bus16.out_ready = 1'b1;
      #3;
      chk("rst_in_ready", bus8.in_ready, 1);
      chk("rst_out_valid", bus8.out_valid, 0);
      chk("rst_busy", bus8.busy, 0);
      chk("rst_bcd_out", bus8.bcd_out, 0);
      chk("rst_w16_bcd_out", bus16.bcd_out, 0);
      #22;
      rst_n = 1'b1;
      tick();

      // Max value, in_ready low through SHIFT and DONE.
      send(255);
      bus8.in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("busy_in_ready", bus8.in_ready, 0);
         if (bus8.out_valid) break;
         chk("busy_flag", bus8.busy, 1);
      end
      drain();

      // Back-to-back with in_valid held high.
      rise_q.delete();
      send(0);
      send(99);
      send(100);
      bus8.in_valid = 1'b0;
      drain();
      chk("b2b_count", rise_q.size(), 3);
      if (rise_q.size() == 3) begin
         chk("b2b_gap0", rise_q[1] - rise_q[0], 10);
         chk("b2b_gap1", rise_q[2] - rise_q[1], 10);
      end

      // Backpressure: result frozen while out_ready is low.
      bus8.out_ready = 1'b0;
      send(173);
      bus8.in_valid = 1'b0;
      wait_ov(20);
      repeat (20) begin
         @(negedge clk);
         chk("bp_bcd_out", bus8.bcd_out, 12'h173);
         chk("bp_out_valid", bus8.out_valid, 1);
         chk("bp_in_ready", bus8.in_ready, 0);
      end
      @(posedge clk); #1;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      @(negedge clk);
      chk("bp_release_in_ready", bus8.in_ready, 1);
      chk("bp_release_out_valid", bus8.out_valid, 0);
      chk("bp_hold_bcd_out", bus8.bcd_out, 12'h173);
      // out_ready with nothing pending changes nothing.
      bus8.out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("idle_out_valid", bus8.out_valid, 0);
      chk("idle_in_ready", bus8.in_ready, 1);
      chk("queue_empty", exp_q.size(), 0);

      // Word offered during SHIFT is held off until IDLE.
      send(42);
      send(200);
      bus8.in_valid = 1'b0;
      drain();

      // Asynchronous reset after four iterations.
      send(231);
      bus8.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_bcd_out", bus8.bcd_out, 0);
      chk("midrst_out_valid", bus8.out_valid, 0);
      chk("midrst_in_ready", bus8.in_ready, 1);
      chk("midrst_busy", bus8.busy, 0);
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      send(231);
      bus8.in_valid = 1'b0;
      drain();

      // Randomized words, gaps and backpressure.
      rnd_or = 1;
      for (int n = 0; n < 30; n++) begin
         send((n == 0) ? 0 : (n == 1) ? 255 : int'($urandom_range(0, 255)));
         bus8.in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      drain();
      rnd_or = 0;
      bus8.out_ready = 1'b1;

      // Wider instance.
      conv16(65535, 20'h65535);
      conv16(10000, 20'h10000);
      conv16(9,     20'h00009);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
- Sequential double-dabble (shift-and-add-3) converter.
- Takes a WIDTH-bit unsigned binary word and produces DIGITS packed BCD digits, each 0-9.
- Sits upstream of the per-digit BCD/display stages. Every output nibble is guaranteed to be a valid BCD digit, so the downstream invalid flag never fires.
- Uses a valid/ready handshake on both sides and converts one word at a time.

Parameters:
- WIDTH, 8, bit width of the binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1. Any other combination is an elaboration-time error ($error in a generate check).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  binary_in is valid this cycle.
- in_ready  out  1  block can accept a new word; high only in IDLE.
- binary_in  in  WIDTH  unsigned value to convert.
- out_valid  out  1  bcd_out holds a completed result.
- out_ready  in  1  downstream accepts the result.
- bcd_out  out  4*DIGITS  packed BCD result; digit 0 (units) is in [3:0].
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset: while rst_n is low, state=IDLE, internal shift register=0, iteration counter=0, bcd_out=0, out_valid=0, busy=0, in_ready=1 (combinational from state). Reset asserted mid-conversion aborts it; the partial result is discarded and never presented.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load bin_reg=binary_in, bcd_reg=0, cnt=0; go to SHIFT.
  - With in_valid=0: stay.
- SHIFT:
  - busy=1, in_ready=0. in_valid and binary_in are ignored.
  - Each edge performs one iteration:
    - For every digit of bcd_reg that is >=5, add 3 to that digit. All digit corrections are computed combinationally in parallel.
    - Then shift {bcd_reg, bin_reg} left by one bit.
    - cnt increments.
  - The edge that completes iteration WIDTH copies the corrected-and-shifted bcd_reg into bcd_out, sets out_valid=1, and goes to DONE.
- DONE:
  - out_valid=1 and bcd_out is stable.
  - Stays until out_valid && out_ready at an edge, which clears out_valid and returns to IDLE.
  - bcd_out keeps its last value after the handshake until the next result is written.
- Latency:
  - Accept edge is E0. Iterations occur on E1..EWIDTH. out_valid is high starting after edge EWIDTH.
  - With out_ready held high, the earliest next accept is edge EWIDTH+2. Throughput is one word per WIDTH+2 cycles.
- Width rules:
  - bcd_reg is 4*DIGITS bits and cnt is clog2(WIDTH+1) bits.
  - The add-3 correction is applied before the shift, only to digits holding 5-9.
  - The parameter constraint guarantees no carry is lost out of the top digit.
- Boundary conditions:
  - binary_in=0 gives an all-zero result.
  - binary_in=2^WIDTH-1 gives the correct maximum.
  - out_ready held low keeps bcd_out and out_valid frozen indefinitely, with no data loss.
  - out_ready high while out_valid=0 has no effect.
  - in_valid held high continuously is accepted only in IDLE. A word offered in SHIFT or DONE is not consumed; upstream must hold it until in_ready.

Test Plan:
- WIDTH=8, DIGITS=3:
  - binary_in=255 with in_valid pulsed in IDLE, out_ready=1: out_valid rises 8 edges after accept, bcd_out=12'h255, in_ready low throughout SHIFT/DONE.
  - binary_in=0, then 99, then 100, back-to-back with in_valid held high: results are 12'h000, 12'h099, 12'h100, each exactly 10 cycles apart. Every bcd_out nibble is <=9.
  - Backpressure: convert 173 with out_ready=0 for 20 cycles: bcd_out=12'h173 and out_valid stay stable and in_ready stays 0. Raising out_ready for one cycle completes the handshake and in_ready returns to 1 on the next cycle.
  - Ignored input: start 42, then drive in_valid=1 with binary_in=200 during SHIFT: the result is 12'h042 and 200 is accepted only after the return to IDLE, giving 12'h200.
  - Reset mid-op: start 231, pull rst_n low asynchronously after 4 iterations: bcd_out=0, out_valid=0, in_ready=1 immediately. After release, converting 231 gives 12'h231.
- WIDTH=16, DIGITS=5: inputs 65535, 10000, 9 give 20'h65535, 20'h10000, 20'h00009 with latency 16 edges. WIDTH=16, DIGITS=4 fails elaboration.
